// File: rtl/frame_pack_pkg.sv
// Shared defaults for the frame packer: payload/sequence widths, buffer depth
// and the drop counter width.
package frame_pack_pkg;
  localparam int unsigned DATA_W_DEF = 4064;
  localparam int unsigned SEQ_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned DROP_CNT_W = 16;
endpackage

// File: rtl/pack_fifo.sv
// Synchronous first-word-fall-through FIFO with push/pop/level. Storage is not
// reset; only pointers and the occupancy count are.
module pack_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is masked to zero whenever nothing valid is presented or a clear is pending.
  assign dout  = (count != '0 && !clr) ? mem[rd_ptr] : '0;
  assign level = count;
endmodule

// File: rtl/frame_packer.sv
// Tags each accepted DUT sample with a sequence number and buffers the frames
// for the DMA side; full handling either stalls the source or drops and counts.
module frame_packer
  import frame_pack_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned SEQ_W        = SEQ_W_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic                      m_axis_c2h_aclk,
  input  logic                      m_axis_c2h_aresetn,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      hbreak,
  output logic                      out_valid,
  output logic [DATA_W+SEQ_W-1:0]   out_data,
  input  logic                      out_ready,
  output logic [SEQ_W-1:0]          seq_num,
  output logic [$clog2(DEPTH):0]    level,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic full;
  logic push;
  logic pop;
  logic drop;

  assign full      = (level == FULL_LVL);
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign hbreak    = in_valid && !in_ready;

  // In drop mode a full buffer still accepts when the head leaves in the same cycle.
  always_comb begin
    if (DROP_ON_FULL) begin
      in_ready = 1'b1;
      push     = in_valid && (!full || pop);
      drop     = in_valid && full && !pop;
    end else begin
      in_ready = !full;
      push     = in_valid && !full;
      drop     = 1'b0;
    end
  end

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      seq_num  <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      seq_num  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) seq_num <= seq_num + 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  pack_fifo #(
    .WIDTH (DATA_W + SEQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (m_axis_c2h_aclk),
    .rst_n (m_axis_c2h_aresetn),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   ({in_data, seq_num}),
    .dout  (out_data),
    .level (level)
  );
endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: one stall-mode and one drop-mode instance.
module tb_frame_packer;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned OW = DW + SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_clr, s_in_valid, s_in_ready, s_hbreak, s_out_valid, s_out_ready;
  logic [DW-1:0] s_in_data;
  logic [OW-1:0] s_out_data;
  logic [SW-1:0] s_seq;
  logic [2:0]    s_level;
  logic [15:0]   s_drop_cnt;

  logic          d_clr, d_in_valid, d_in_ready, d_hbreak, d_out_valid, d_out_ready;
  logic [DW-1:0] d_in_data;
  logic [OW-1:0] d_out_data;
  logic [SW-1:0] d_seq;
  logic [2:0]    d_level;
  logic [15:0]   d_drop_cnt;

  int checks = 0;
  int errors = 0;

  frame_packer #(.DATA_W(DW), .SEQ_W(SW), .DEPTH(D), .DROP_ON_FULL(1'b0)) u_stall (
    .m_axis_c2h_aclk(clk), .m_axis_c2h_aresetn(rst_n), .clr(s_clr),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready), .hbreak(s_hbreak),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .seq_num(s_seq), .level(s_level), .drop_cnt(s_drop_cnt));

  frame_packer #(.DATA_W(DW), .SEQ_W(SW), .DEPTH(D), .DROP_ON_FULL(1'b1)) u_drop (
    .m_axis_c2h_aclk(clk), .m_axis_c2h_aresetn(rst_n), .clr(d_clr),
    .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready), .hbreak(d_hbreak),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(d_out_ready),
    .seq_num(d_seq), .level(d_level), .drop_cnt(d_drop_cnt));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    s_clr = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0;
    d_clr = 0; d_in_valid = 0; d_in_data = '0; d_out_ready = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    rst_n = 0;
    s_in_valid = 1; d_in_valid = 1;
    #1;
    checks++; if (s_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", s_level); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", s_out_valid); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", s_in_ready); end
    checks++; if (s_hbreak !== 1'b0) begin errors++; $display("FAIL reset_hbreak got %0b exp 0", s_hbreak); end
    checks++; if (s_seq !== 8'd0) begin errors++; $display("FAIL reset_seq got %0h exp 0", s_seq); end
    checks++; if (s_out_data !== 40'd0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", s_out_data); end
    checks++; if (d_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0h exp 0", d_drop_cnt); end
    s_in_valid = 0; d_in_valid = 0;
    rst_n = 1;
    #1;
  endtask

  task automatic test_single;
    do_reset();
    s_in_valid = 1; s_in_data = 32'hA5;
    step();
    s_in_valid = 0;
    #1;
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", s_out_valid); end
    checks++; if (s_out_data !== {32'hA5, 8'h00}) begin errors++; $display("FAIL single_data got %0h exp %0h", s_out_data, {32'hA5, 8'h00}); end
    checks++; if (s_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", s_level); end
    s_out_ready = 1;
    step();
    s_out_ready = 0;
    #1;
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %0b exp 0", s_out_valid); end
    checks++; if (s_seq !== 8'd1) begin errors++; $display("FAIL single_seq got %0h exp 1", s_seq); end
  endtask

  task automatic test_stall;
    bit accepted = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1; s_in_data = DW'(32'h100 + i);
      step();
    end
    s_in_data = 32'h104;
    #1;
    checks++; if (s_level !== 3'd4) begin errors++; $display("FAIL stall_level got %0d exp 4", s_level); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b exp 0", s_in_ready); end
    checks++; if (s_hbreak !== 1'b1) begin errors++; $display("FAIL stall_hbreak got %0b exp 1", s_hbreak); end
    checks++; if (s_seq !== 8'd4) begin errors++; $display("FAIL stall_seq_hold got %0h exp 4", s_seq); end
    s_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      bit acc_now;
      #1;
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== {DW'(32'h100 + k), SW'(k)}) begin
        errors++; $display("FAIL stall_drain%0d got %0b/%0h exp 1/%0h", k, s_out_valid, s_out_data, {DW'(32'h100 + k), SW'(k)});
      end
      acc_now = s_in_valid && s_in_ready;
      step();
      if (acc_now) begin accepted = 1; s_in_valid = 0; end
    end
    s_out_ready = 0;
    #1;
    checks++; if (accepted !== 1'b1) begin errors++; $display("FAIL stall_accept got %0b exp 1", accepted); end
    checks++; if (s_level !== 3'd0) begin errors++; $display("FAIL stall_empty got %0d exp 0", s_level); end
    checks++; if (s_seq !== 8'd5) begin errors++; $display("FAIL stall_seq_end got %0h exp 5", s_seq); end
  endtask

  task automatic test_drop;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d_in_valid = 1; d_in_data = DW'(32'h200 + i);
      #1;
      checks++; if (d_hbreak !== 1'b0 || d_in_ready !== 1'b1) begin errors++; $display("FAIL drop_hs%0d got hbreak=%0b ready=%0b exp 0/1", i, d_hbreak, d_in_ready); end
      step();
    end
    d_in_valid = 0;
    #1;
    checks++; if (d_level !== 3'd4) begin errors++; $display("FAIL drop_level got %0d exp 4", d_level); end
    checks++; if (d_drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d exp 2", d_drop_cnt); end
    checks++; if (d_seq !== 8'd4) begin errors++; $display("FAIL drop_seq got %0h exp 4", d_seq); end
    d_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (d_out_data !== {DW'(32'h200 + k), SW'(k)}) begin
        errors++; $display("FAIL drop_drain%0d got %0h exp %0h", k, d_out_data, {DW'(32'h200 + k), SW'(k)});
      end
      step();
    end
    d_out_ready = 0;
    #1;
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL drop_empty got %0b exp 0", d_out_valid); end
  endtask

  task automatic test_wrap;
    do_reset();
    s_out_ready = 1;
    for (int i = 0; i < 257; i++) begin
      s_in_valid = 1; s_in_data = DW'(i);
      #1;
      if (i > 0) begin
        checks++;
        if (s_out_data !== {DW'(i - 1), SW'(i - 1)}) begin
          errors++; $display("FAIL wrap_frame%0d got %0h exp %0h", i - 1, s_out_data, {DW'(i - 1), SW'(i - 1)});
        end
      end
      if (i == 256) begin
        checks++; if (s_out_data[7:0] !== 8'hFF) begin errors++; $display("FAIL wrap_seq_ff got %0h exp ff", s_out_data[7:0]); end
      end
      step();
    end
    s_in_valid = 0;
    #1;
    checks++; if (s_out_data !== {32'd256, 8'h00}) begin errors++; $display("FAIL wrap_seq_00 got %0h exp %0h", s_out_data, {32'd256, 8'h00}); end
    checks++; if (s_seq !== 8'h01) begin errors++; $display("FAIL wrap_seq_num got %0h exp 01", s_seq); end
    step();
    s_out_ready = 0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d_in_valid = 1; d_in_data = DW'(32'h300 + i);
      step();
    end
    d_out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      d_in_data = DW'(32'h304 + k);
      #1;
      checks++;
      if (d_out_data !== {DW'(32'h300 + k), SW'(k)}) begin
        errors++; $display("FAIL b2b_head%0d got %0h exp %0h", k, d_out_data, {DW'(32'h300 + k), SW'(k)});
      end
      step();
      checks++; if (d_level !== 3'd4) begin errors++; $display("FAIL b2b_level%0d got %0d exp 4", k, d_level); end
    end
    d_in_valid = 0; d_out_ready = 0;
    #1;
    checks++; if (d_drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drops got %0d exp 0", d_drop_cnt); end
    checks++; if (d_seq !== 8'd14) begin errors++; $display("FAIL b2b_seq got %0d exp 14", d_seq); end
  endtask

  task automatic test_clear;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1; s_in_data = DW'(32'h400 + i);
      step();
    end
    s_in_valid = 0;
    #1;
    checks++; if (s_level !== 3'd3) begin errors++; $display("FAIL clr_pre_level got %0d exp 3", s_level); end
    s_clr = 1; s_in_valid = 1; s_out_ready = 1;
    #1;
    checks++; if (s_out_data !== 40'd0) begin errors++; $display("FAIL clr_out_data got %0h exp 0", s_out_data); end
    step();
    s_clr = 0; s_in_valid = 0; s_out_ready = 0;
    #1;
    checks++; if (s_level !== 3'd0) begin errors++; $display("FAIL clr_level got %0d exp 0", s_level); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid got %0b exp 0", s_out_valid); end
    checks++; if (s_seq !== 8'd0) begin errors++; $display("FAIL clr_seq got %0h exp 0", s_seq); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready got %0b exp 1", s_in_ready); end
    s_in_valid = 1; s_in_data = 32'h77;
    step();
    s_in_valid = 0;
    #1;
    checks++; if (s_out_data !== {32'h77, 8'h00}) begin errors++; $display("FAIL clr_first got %0h exp %0h", s_out_data, {32'h77, 8'h00}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_drop();
    test_wrap();
    test_back_to_back();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter DATA_W, default 4064, SHALL set the captured payload width in bits.
REQ-002 Parameter SEQ_W, default 8, SHALL set the sequence-number width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the frame-buffer depth; it SHALL be a power of two and at least 2.
REQ-004 Parameter DROP_ON_FULL, default 0, SHALL select full handling: 0 = stall the source, 1 = drop and count.
REQ-005 m_axis_c2h_aclk  in  1  SHALL be the single clock for all logic.
REQ-006 m_axis_c2h_aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 clr  in  1  SHALL be the synchronous clear; it is active high.
REQ-008 in_valid  in  1  SHALL indicate that the DUT sample is valid this cycle.
REQ-009 in_data  in  DATA_W  SHALL carry the DUT IO payload.
REQ-010 in_ready  out  1  SHALL indicate that the block can accept a sample.
REQ-011 hbreak  out  1  SHALL halt the DUT; it is asserted when in_valid=1 and in_ready=0.
REQ-012 out_valid  out  1  SHALL indicate that a frame is presented to the DMA side.
REQ-013 out_data  out  DATA_W+SEQ_W  SHALL carry the frame as {payload, seq}, with seq in the LSBs.
REQ-014 out_ready  in  1  SHALL indicate that the DMA side consumes the head frame this cycle.
REQ-015 seq_num  out  SEQ_W  SHALL give the sequence number that the next accepted sample will receive.
REQ-016 level  out  $clog2(DEPTH)+1  SHALL give the number of frames currently buffered.
REQ-017 drop_cnt  out  16  SHALL count dropped samples and saturate at 0xFFFF.

Function
REQ-018 A capture SHALL occur on a clock edge when in_valid=1 and in_ready=1; the captured frame is {in_data, seq_num}.
REQ-019 seq_num SHALL increment by 1 on each capture, modulo 2^SEQ_W, wrapping from all-ones to 0.
REQ-020 Frames SHALL leave in capture order (FIFO); out_data SHALL be first-word-fall-through and stable while out_valid=1 and out_ready=0.
REQ-021 Latency: a capture into an empty buffer SHALL raise out_valid on the following cycle.
REQ-022 A pop SHALL occur when out_valid=1 and out_ready=1; the next frame, if any, SHALL be presented in the following cycle with no bubble.
REQ-023 out_valid SHALL equal (level != 0).
REQ-024 When DROP_ON_FULL=0, in_ready SHALL equal (level < DEPTH).
REQ-025 When DROP_ON_FULL=1, in_ready SHALL be constantly 1 and hbreak constantly 0.
REQ-026 When DROP_ON_FULL=1 and in_valid=1 at level=DEPTH with no simultaneous pop, the sample SHALL be discarded, seq_num SHALL NOT increment, and drop_cnt SHALL increment.
REQ-027 A simultaneous push and pop at level=DEPTH SHALL complete both operations; level stays at DEPTH and nothing is dropped.
REQ-028 A simultaneous push and pop at any level SHALL leave level unchanged.
REQ-029 A pop at level=0 SHALL be impossible, because out_valid=0.
REQ-030 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally.
REQ-031 clr=1 SHALL override push and pop in the same cycle.

Reset
REQ-032 Asynchronous reset (m_axis_c2h_aresetn=0) and clr=1 SHALL both force level=0, seq_num=0, drop_cnt=0, pointers=0 and out_valid=0.
REQ-033 Under those conditions in_ready SHALL be 1, and hbreak SHALL be 0 only because in_ready=1.
REQ-034 During reset and clear, out_data SHALL read 0; buffer storage SHALL NOT be reset.
REQ-035 A reset or clear in the middle of a transfer SHALL discard all buffered frames, and the first capture afterwards SHALL carry seq=0.

Structure
REQ-036 Package frame_pack_pkg SHALL hold the default DATA_W, SEQ_W and DEPTH constants and the drop_cnt width constant (16).
REQ-037 Storage and pointers SHALL be in one sub-module, pack_fifo (a synchronous FWFT FIFO with push/pop/level).
REQ-038 frame_packer SHALL hold the sequence counter, the drop counter and the handshake logic around pack_fifo.

Verification
REQ-039 Single frame: after reset, push in_data=0xA5 (zero-extended) -> the next cycle out_valid=1 and out_data={0xA5, 8'h00}; pop -> out_valid=0, seq_num=1.
REQ-040 Stall mode: DEPTH=4, out_ready=0, push 5 samples -> level=4, in_ready=0, hbreak=1 on the 5th; set out_ready=1 -> frames seq 0..3 drain in order, then the 5th is accepted with seq 4.
REQ-041 Drop mode: DROP_ON_FULL=1, DEPTH=4, out_ready=0, push 6 samples -> level=4, drop_cnt=2, seq_num=4, hbreak=0.
REQ-042 Wrap: capture 257 frames with out_ready=1 -> the 256th carries seq 0xFF and the 257th carries seq 0x00.
REQ-043 Concurrent: level=4, in_valid=1 and out_ready=1 for 10 cycles -> level stays 4, no drops, sequence numbers contiguous.
REQ-044 Mid-operation clear: level=3, pulse clr for 1 cycle -> the next cycle level=0 and out_valid=0; the next capture carries seq 0.
